seq_magnitude_comparator: RTL
=============================

# seq_magnitude_comparator

Parametrised bit-serial magnitude comparator that compares two WIDTH-bit operands MSB-first, DIGIT bits per cycle, with optional two's-complement (signed) mode. It terminates early at the first differing digit. It uses a start/busy/done handshake and holds its registered L/E/G result until the next accepted start. It is the multi-width, signed-capable, early-terminating successor to the team's fixed 32-bit serial comparator, and is used wherever a datapath needs an area-cheap ordered compare.

## Interface
Parameters:
- WIDTH, 32, operand width in bits; must be ≥ 1.
- DIGIT, 1, bits compared per cycle; must be ≥ 1 and divide WIDTH exactly. Any other value is an elaboration error.
- Derived: NCHUNK = WIDTH/DIGIT; CNT_W = $clog2(NCHUNK)+1.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  request; sampled only while busy=0.
- inp1  in  WIDTH  operand A; captured when start is accepted.
- inp2  in  WIDTH  operand B; captured when start is accepted.
- is_signed  in  1  1 = two's-complement compare, 0 = unsigned; captured when start is accepted.
- busy  out  1  high while a compare is in progress.
- done  out  1  one-cycle pulse; result valid.
- L  out  1  A < B.
- E  out  1  A == B.
- G  out  1  A > B.
- count  out  CNT_W  number of digits examined (1..NCHUNK); valid from done onward.

## Operation
- FSM has two states: IDLE and COMPARE.
- **IDLE, start=1:**
  - Load shift registers sa←inp1 and sb←inp2.
  - If is_signed=1, invert the MSB of both loaded values. This maps signed order onto unsigned order.
  - Clear L/E/G/count to 0, set remaining←NCHUNK, assert busy, go to COMPARE.
- **COMPARE, each cycle:** compare the top DIGIT bits of sa and sb as unsigned values, and increment count.
  - If digits differ: set L or G per the digit compare, deassert busy, pulse done, go to IDLE.
  - If digits are equal and remaining=1: set E, deassert busy, pulse done, go to IDLE.
  - Otherwise: shift sa and sb left by DIGIT, decrement remaining, stay in COMPARE.
- At most one of L/E/G is high at any time. All three are 0 from reset until the first done, and 0 from each accepted start until its done.
- L/E/G/count hold their values after done until the next accepted start.
- start while busy=1 is ignored. Operand changes after acceptance have no effect.
- **Reset, including mid-compare:** state=IDLE, busy=0, done=0, L=E=G=0, count=0, shift registers cleared. No partial result survives.

## Timing
- start is accepted at rising edge e0 (state IDLE). busy=1 after e0.
- The digit compare for chunk k (1-based) resolves at edge ek.
- A compare deciding at chunk n (1 ≤ n ≤ NCHUNK) gives, after edge en:
  - busy=0;
  - done=1 for exactly one cycle;
  - L/E/G and count=n valid together.
- Latency from the accepting edge to done is n cycles. Worst case is NCHUNK cycles (equal operands).
- Back-to-back operation: start high during the done cycle is accepted at en+1. done falls and L/E/G clear at that same edge. Throughput is one compare per n+1 cycles with zero idle cycles.
- All outputs are registered; no combinational path runs from inputs to outputs.
- reset acts asynchronously on assertion. Release is expected synchronous to clk. The first start is sampled at the first edge after release.

## Test plan
- WIDTH=32, DIGIT=1, unsigned, inp1=0x8000_0000, inp2=0x7FFF_FFFF → done 1 cycle after accepting edge, G=1, L=E=0, count=1.
- WIDTH=32, DIGIT=1, inp1=inp2=0x1234_5678 → busy high 32 cycles, then done with E=1 and count=32; L/E/G were 0 throughout busy.
- Signed mode, WIDTH=32, DIGIT=1, inp1=0xFFFF_FFFF, inp2=0x0000_0001:
  - is_signed=1 → L=1, count=1.
  - same operands with is_signed=0 → G=1, count=1.
  - is_signed=1, 0x8000_0000 vs 0x7FFF_FFFF → L=1.
- WIDTH=32, DIGIT=4:
  - 0x1234_5670 vs 0x1234_5678 → L=1, count=8.
  - 0x1300_0000 vs 0x12FF_FFFF → G=1, count=2.
  - DIGIT=3 with WIDTH=32 → elaboration fails.
- Protocol and reset:
  - start pulsed while busy, with changed operands → ignored; original result returned.
  - reset asserted mid-compare (asynchronously, between edges) → busy/done/L/E/G/count go 0 immediately; next start after release completes normally.
- start held high continuously over three operand pairs → each compare accepted in the prior done cycle; three done pulses, each with the correct result and no idle gap.

Source files
------------

// File: rtl/seq_magnitude_comparator_if.sv
// Handshake and operand/result bundle for the bit-serial magnitude comparator.
// The master issues start and operands; the slave (the comparator) returns
// busy/done and the registered L/E/G/count result.
interface seq_magnitude_comparator_if #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
);
    localparam int NCHUNK = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
    localparam int CNT_W  = $clog2(NCHUNK) + 1;

    logic             start;
    logic [WIDTH-1:0] inp1;
    logic [WIDTH-1:0] inp2;
    logic             is_signed;
    logic             busy;
    logic             done;
    logic             L;
    logic             E;
    logic             G;
    logic [CNT_W-1:0] count;

    modport master (
        output start, inp1, inp2, is_signed,
        input  busy, done, L, E, G, count
    );

    modport slave (
        input  start, inp1, inp2, is_signed,
        output busy, done, L, E, G, count
    );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// Bit-serial MSB-first magnitude comparator, DIGIT bits per cycle, with an
// optional two's-complement mode and early termination at the first differing
// digit. Results are registered and held until the next accepted start.
module seq_magnitude_comparator #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    seq_magnitude_comparator_if.slave     cmp
);
    localparam int NCHUNK = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
    localparam int CNT_W  = $clog2(NCHUNK) + 1;

    // Reject operand widths that do not split into whole digits.
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("seq_magnitude_comparator: DIGIT must be >= 1 and divide WIDTH");
    end

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_COMPARE = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] r_count;
    logic             r_busy;
    logic             r_done;
    logic             r_l;
    logic             r_e;
    logic             r_g;

    logic [WIDTH-1:0] w_sign_mask;
    logic [DIGIT-1:0] w_da;
    logic [DIGIT-1:0] w_db;

    // Flipping the sign bit of both operands turns a signed order into an
    // unsigned order, so the digit datapath never needs to know the mode.
    assign w_sign_mask = cmp.is_signed ? (WIDTH'(1) << (WIDTH - 1)) : '0;

    // Current most-significant digit of each operand.
    assign w_da = r_sa[WIDTH-1 -: DIGIT];
    assign w_db = r_sb[WIDTH-1 -: DIGIT];

    // Control FSM and datapath: load on start, resolve one digit per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sa        <= '0;
            r_sb        <= '0;
            r_remaining <= '0;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_l         <= 1'b0;
            r_e         <= 1'b0;
            r_g         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmp.start) begin
                        r_sa        <= cmp.inp1 ^ w_sign_mask;
                        r_sb        <= cmp.inp2 ^ w_sign_mask;
                        r_l         <= 1'b0;
                        r_e         <= 1'b0;
                        r_g         <= 1'b0;
                        r_count     <= '0;
                        r_remaining <= CNT_W'(NCHUNK);
                        r_busy      <= 1'b1;
                        r_state     <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    r_count <= r_count + CNT_W'(1);
                    if (w_da != w_db) begin
                        // First differing digit decides the order.
                        r_l     <= (w_da < w_db);
                        r_g     <= (w_da > w_db);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (r_remaining == CNT_W'(1)) begin
                        r_e     <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_sa        <= r_sa << DIGIT;
                        r_sb        <= r_sb << DIGIT;
                        r_remaining <= r_remaining - CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmp.busy  = r_busy;
    assign cmp.done  = r_done;
    assign cmp.L     = r_l;
    assign cmp.E     = r_e;
    assign cmp.G     = r_g;
    assign cmp.count = r_count;
endmodule
